// File: rtl/cp0_timer_regs.sv
// cp0_timer_regs
//   CP0 register block: BadVAddr, Count (with prescaler), Compare, Status,
//   Cause and EPC. Accepts MTC0 writes from write-back, serves combinational
//   MFC0 reads to execute, commits exceptions/ERET and raises int_req.
//
// Parameters
//   HW_INT_NUM : hardware interrupt lines (1..6), mapped onto IP2 upward
//   COUNT_DIV  : Count advances once every COUNT_DIV clocks (1..16)
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   mtc0_we/addr/wdata               MTC0 write port
//   mfc0_addr / mfc0_rdata           MFC0 read port (combinational)
//   exc_valid/code/bd/pc             exception commit
//   exc_badva_we / exc_badva         BadVAddr update with the commit
//   eret                             ERET commit
//   hw_int                           level-sensitive hardware interrupts
//   epc_out, status_exl, timer_int   register views for the pipeline
//   int_req                          pending enabled interrupt
module cp0_timer_regs #(
  parameter int HW_INT_NUM = 6,
  parameter int COUNT_DIV  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mtc0_we,
  input  logic [4:0]            mtc0_addr,
  input  logic [31:0]           mtc0_wdata,
  input  logic [4:0]            mfc0_addr,
  output logic [31:0]           mfc0_rdata,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic                  exc_bd,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_badva_we,
  input  logic [31:0]           exc_badva,
  input  logic                  eret,
  input  logic [HW_INT_NUM-1:0] hw_int,
  output logic [31:0]           epc_out,
  output logic                  status_exl,
  output logic                  timer_int,
  output logic                  int_req
);

  localparam logic [4:0] ADDR_BADVA   = 5'd8;
  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;

  localparam logic [3:0] PRESC_MAX = 4'(COUNT_DIV - 1);

  logic [31:0]           badva_q;
  logic [31:0]           count_q;
  logic [3:0]            presc_q;
  logic [31:0]           compare_q;
  logic [7:0]            im_q;
  logic                  exl_q;
  logic                  ie_q;
  logic                  bd_q;
  logic                  ti_q;
  logic [1:0]            ip_sw_q;
  logic [4:0]            exccode_q;
  logic [31:0]           epc_q;
  logic [HW_INT_NUM-1:0] hw_q;

  // An exception commit flushes the instruction carrying the MTC0.
  logic wr;
  assign wr = mtc0_we & ~exc_valid;

  logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  assign wr_count   = wr && (mtc0_addr == ADDR_COUNT);
  assign wr_compare = wr && (mtc0_addr == ADDR_COMPARE);
  assign wr_status  = wr && (mtc0_addr == ADDR_STATUS);
  assign wr_cause   = wr && (mtc0_addr == ADDR_CAUSE);
  assign wr_epc     = wr && (mtc0_addr == ADDR_EPC);

  // Zero-extend the registered lines to six so unused IP bits read 0.
  logic [5:0] hw_pad;
  logic [7:0] ip;
  assign hw_pad = 6'(hw_q);
  assign ip     = {hw_pad[5] | ti_q, hw_pad[4:0], ip_sw_q};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which is what makes same-cycle read-old work.
  // NOTE: every register here is a discrete flop with a reset value; there is
  // no memory array, so the whole block returns to a known state on rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      badva_q   <= '0;
      count_q   <= '0;
      presc_q   <= '0;
      compare_q <= '0;
      im_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ti_q      <= 1'b0;
      ip_sw_q   <= '0;
      exccode_q <= '0;
      epc_q     <= '0;
      hw_q      <= '0;
    end else begin
      hw_q <= hw_int;

      if (wr_count) begin
        count_q <= mtc0_wdata;
        presc_q <= '0;
      end else if (presc_q == PRESC_MAX) begin
        count_q <= count_q + 32'd1;
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + 4'd1;
      end

      if (wr_compare) compare_q <= mtc0_wdata;

      // Compare write clears TI and wins over a coincident match.
      if (wr_compare)                  ti_q <= 1'b0;
      else if (count_q == compare_q)   ti_q <= 1'b1;

      if (wr_status) begin
        im_q <= mtc0_wdata[15:8];
        ie_q <= mtc0_wdata[0];
      end

      if (exc_valid)      exl_q <= 1'b1;
      else if (eret)      exl_q <= 1'b0;
      else if (wr_status) exl_q <= mtc0_wdata[1];

      if (wr_cause) ip_sw_q <= mtc0_wdata[9:8];

      if (exc_valid) begin
        exccode_q <= exc_code;
        // A nested exception keeps the original return point.
        if (!exl_q) begin
          epc_q <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
          bd_q  <= exc_bd;
        end
        if (exc_badva_we) badva_q <= exc_badva;
      end else if (wr_epc) begin
        epc_q <= mtc0_wdata;
      end
    end
  end

  logic [31:0] status_val, cause_val;
  assign status_val = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_val  = {bd_q, ti_q, 14'b0, ip, 1'b0, exccode_q, 2'b0};

  // NOTE: a default ahead of the case keeps this purely combinational; a
  // missing assignment on any path would infer a latch.
  always_comb begin
    mfc0_rdata = '0;
    case (mfc0_addr)
      ADDR_BADVA:   mfc0_rdata = badva_q;
      ADDR_COUNT:   mfc0_rdata = count_q;
      ADDR_COMPARE: mfc0_rdata = compare_q;
      ADDR_STATUS:  mfc0_rdata = status_val;
      ADDR_CAUSE:   mfc0_rdata = cause_val;
      ADDR_EPC:     mfc0_rdata = epc_q;
      default:      mfc0_rdata = '0;
    endcase
  end

  assign epc_out    = epc_q;
  assign status_exl = exl_q;
  assign timer_int  = ti_q;
  assign int_req    = ie_q & ~exl_q & (|(ip & im_q));

endmodule

// File: doc/cp0_timer_regs.md
# cp0_timer_regs

Parametrised CP0 register block for the 5-stage pipelined CPU, the successor to the fixed six-register CP0 file. It holds BadVAddr, Count, Compare, Status, Cause and EPC, and adds a configurable Count prescaler and a configurable number of hardware interrupt lines. It also takes exception/ERET commit requests from the pipeline's commit point and generates the interrupt request back to the pipeline. MTC0 writes enter at the write-back stage; MFC0 reads are combinational for the execute stage.

## Interface
Parameters:
- HW_INT_NUM, 6: number of hardware interrupt inputs (1..6), mapped to IP2 upward.
- COUNT_DIV, 2: Count increments once every COUNT_DIV clocks (1..16).

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- mtc0_we  in  1  MTC0 write strobe.
- mtc0_addr  in  5  CP0 register number for the write (sel 0 only).
- mtc0_wdata  in  32  write data.
- mfc0_addr  in  5  CP0 register number for the read.
- mfc0_rdata  out  32  read data, combinational.
- exc_valid  in  1  exception commit, one cycle per exception.
- exc_code  in  5  ExcCode for the committed exception.
- exc_bd  in  1  faulting instruction is in a branch delay slot.
- exc_pc  in  32  PC of the faulting instruction.
- exc_badva_we  in  1  update BadVAddr; meaningful only with exc_valid.
- exc_badva  in  32  faulting address.
- eret  in  1  ERET commit.
- hw_int  in  HW_INT_NUM  level-sensitive hardware interrupts.
- epc_out  out  32  current EPC, used as the ERET target.
- status_exl  out  1  Status.EXL.
- timer_int  out  1  Cause.TI.
- int_req  out  1  pending enabled interrupt.

## Operation
**Register map** (all other numbers read 0 and ignore writes):
- 8 BadVAddr: read-only to MTC0.
- 9 Count.
- 11 Compare.
- 12 Status.
- 13 Cause.
- 14 EPC.

**Status**
- Bit 22 (BEV) reads constant 1.
- IM[7:0] (bits 15:8), EXL (bit 1) and IE (bit 0) are writable.
- All other bits read 0.

**Cause**
- Bit 31: BD.
- Bit 30: TI.
- Bits 15:8: IP[7:0].
- Bits 6:2: ExcCode.
- All other bits read 0.
- IP[1:0] are MTC0-writable.
- IP[2+i] is hw_int[i], registered each cycle.
- IP bits beyond HW_INT_NUM read 0.
- IP7 = registered hw_int[5] (if present) OR TI.

**Count**
- A prescaler counts 0..COUNT_DIV-1. Count increments when the prescaler is at COUNT_DIV-1, and the prescaler then returns to 0.
- Count wraps 0xFFFFFFFF -> 0.
- An MTC0 to Count loads the value and clears the prescaler.

**TI**
- Set on the clock edge at which Count == Compare.
- Cleared by any MTC0 to Compare. The clear wins over a same-cycle set.
- Otherwise holds.

**Exception commit** (exc_valid=1):
- EXL <= 1.
- ExcCode <= exc_code.
- If EXL was 0: EPC <= exc_bd ? exc_pc-4 : exc_pc, and BD <= exc_bd.
- If EXL was 1: EPC and BD are unchanged.
- If exc_badva_we: BadVAddr <= exc_badva.

**ERET**
- EXL <= 0.

**Priority**
- exc_valid beats eret; a same-cycle eret is ignored.
- exc_valid also suppresses any same-cycle MTC0, because that instruction is being flushed.
- eret beats an MTC0 write to EXL.

**EPC writes**
- MTC0 writes EPC regardless of EXL.

**int_req**
- int_req = IE & ~EXL & |(IP & IM), computed combinationally from registered state.
- The pipeline answers it with exc_valid, exc_code=0.

**Reads**
- mfc0_rdata reflects register state before the current edge.
- A read and a write to the same register in the same cycle returns the old value.

## Timing
- All state updates on the rising edge of clk.
- mfc0_rdata, epc_out, int_req, status_exl and timer_int are combinational from registers: zero added latency.
- hw_int to IP: 1 cycle. hw_int to int_req: 1 cycle.
- Count==Compare to TI/int_req: 1 cycle.
- Reset (asynchronous, any time, including mid-exception):
  - All registers 0 except Status.BEV=1.
  - Prescaler 0.
  - Outputs after reset: mfc0_rdata=0 for all addresses except Status=0x00400000; epc_out=0; status_exl=0; timer_int=0; int_req=0.
- Count runs from the first edge after rst_n deasserts.

## Test plan
- **Prescaler:** with COUNT_DIV=2, write Count=5, then wait 6 clocks -> Count reads 8. With COUNT_DIV=1 from 0xFFFFFFFE, 2 clocks -> reads 0 (wrap).
- **Timer interrupt:**
  - Write Compare=20, Status=0x00008001, Count=18, and let Count advance to 20 -> TI=1, Cause bit 15=1, int_req=1 one cycle later.
  - MTC0 Compare -> TI=0 on the next cycle.
- **Exception commit:** exc_valid with exc_pc=0x80001004, exc_bd=1, code 4, badva 0x13 -> EPC=0x80001000, BD=1, ExcCode=4, BadVAddr=0x13, EXL=1, int_req=0.
- **Nested exception:** a second exc_valid (exc_pc=0x200, code 8) while EXL=1 -> EPC and BD unchanged, ExcCode=8.
- **Priority:** exc_valid, eret and MTC0 EPC=0x55 in the same cycle -> EXL=1, EPC from exc_pc, not 0x55.
- **Async reset and IP mapping:**
  - Assert rst_n low mid-count -> Count=0, Status=0x00400000 immediately, without waiting for a clock edge.
  - With HW_INT_NUM=2, drive hw_int=2'b10 -> Cause=0x00000800.
